// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage : MEM/WB pipeline stage of the MiniRiscV core.
//
// Accepts retiring instructions from MEM. Non-loads retire on the next clock
// edge. Loads retire on the next edge if load data arrives in the same cycle.
// Otherwise the control fields are held and the stage waits for load data.
// Load bytes/halfwords are extracted and extended, the writeback source is
// selected, and a retire counter is kept. All writeback outputs are registered
// on posedge clk, so they are stable for the register file's negedge write.
//
// Handshake: an instruction is taken when in_valid=1 and in_ready=1 with
// flush=0. in_ready is high only in IDLE; stall_req is its complement and tells
// MEM to hold while a load is outstanding. in_valid is ignored while waiting.
//
// Ports:
//   clk, reset          clock (posedge) / synchronous active-high reset
//   in_valid, in_ready  MEM-side handshake
//   in_rd, in_reg_write destination register and its write flag
//   in_wb_sel           00 ALU, 01 load, 10 PC+4, 11 immediate
//   in_alu_result, in_pc_plus4, in_imm   candidate writeback values
//   in_funct3, in_addr_lo                load type / low address bits
//   load_valid, load_rdata               load data return (aligned word)
//   flush               kill the held or incoming instruction
//   wb_valid, wb_we, wb_rd, wb_data      register-file write port (pulsed)
//   stall_req           upstream must hold (state is WAIT_DATA)
//   retire_count        free-running count of retired instructions
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    input  logic [1:0]       in_wb_sel,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_pc_plus4,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic             load_valid,
    input  logic [XLEN-1:0]  load_rdata,
    input  logic             flush,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             stall_req,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DATA = 1'b1
    } state_t;

    state_t      r_state;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;

    logic            w_accept;
    logic            w_is_load;
    logic            w_retire;
    logic            w_capture;
    logic [4:0]      w_sel_rd;
    logic            w_sel_we;
    logic [2:0]      w_f3;
    logic [1:0]      w_lo;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_sel_data;

    assign in_ready  = (r_state == IDLE);
    assign stall_req = (r_state == WAIT_DATA);

    assign w_accept  = (r_state == IDLE) && in_valid && !flush;
    assign w_is_load = (in_wb_sel == 2'b01);
    // Flush wins over both a fresh accept and returning load data.
    assign w_retire  = (w_accept && (!w_is_load || load_valid)) ||
                       ((r_state == WAIT_DATA) && load_valid && !flush);
    assign w_capture = w_accept && w_is_load && !load_valid;

    // In WAIT_DATA the MEM-side inputs belong to a stalled younger
    // instruction, so the held fields must be used instead.
    always_comb begin
        w_sel_rd = in_rd;
        w_sel_we = in_reg_write;
        w_f3     = in_funct3;
        w_lo     = in_addr_lo;
        if (r_state == WAIT_DATA) begin
            w_sel_rd = r_rd;
            w_sel_we = r_reg_write;
            w_f3     = r_funct3;
            w_lo     = r_addr_lo;
        end
    end

    // Load extraction; addr_lo[0] is irrelevant for halfwords, and
    // undefined funct3 codes fall through to a full-word load.
    always_comb begin
        w_byte = 8'h00;
        case (w_lo)
            2'd0:    w_byte = load_rdata[7:0];
            2'd1:    w_byte = load_rdata[15:8];
            2'd2:    w_byte = load_rdata[23:16];
            default: w_byte = load_rdata[31:24];
        endcase
        w_half = w_lo[1] ? load_rdata[31:16] : load_rdata[15:0];
        w_load_data = load_rdata;
        case (w_f3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = load_rdata;
        endcase
    end

    always_comb begin
        w_sel_data = in_alu_result;
        if (r_state == WAIT_DATA) begin
            w_sel_data = w_load_data;
        end else begin
            case (in_wb_sel)
                2'b00:   w_sel_data = in_alu_result;
                2'b01:   w_sel_data = w_load_data;
                2'b10:   w_sel_data = in_pc_plus4;
                default: w_sel_data = in_imm;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rd         <= 5'd0;
            r_reg_write  <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr_lo    <= 2'd0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= '0;
            retire_count <= '0;
        end else begin
            wb_valid <= w_retire;
            // x0 is never written even though the instruction retires.
            wb_we    <= w_retire && w_sel_we && (w_sel_rd != 5'd0);
            if (w_retire) begin
                wb_rd        <= w_sel_rd;
                wb_data      <= w_sel_data;
                retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_rd        <= in_rd;
                        r_reg_write <= in_reg_write;
                        r_funct3    <= in_funct3;
                        r_addr_lo   <= in_addr_lo;
                        r_state     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (flush || load_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage : self-checking bench for wb_stage.
// A driver issues instructions (directed then random) and pushes expected
// retirements into exp_q; a negedge monitor pops and compares whenever the
// DUT pulses wb_valid. A second instance with a 4-bit counter shares the
// inputs so counter wrap-around is exercised.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  localparam int EW = 70;  // {cycle[31:0], rd[4:0], we, data[31:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result, in_pc_plus4, in_imm;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        load_valid;
  logic [31:0] load_rdata;
  logic        flush;

  logic        in_ready, wb_valid, wb_we, stall_req;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, retire_count;

  logic        s_in_ready, s_wb_valid, s_wb_we, s_stall_req;
  logic [4:0]  s_wb_rd;
  logic [31:0] s_wb_data;
  logic [3:0]  s_retire_count;

  logic [EW-1:0] exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  exp_count = 0;
  bit  exp_wait = 1'b0;
  bit  mon_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_stage #(.XLEN(32), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .load_valid(load_valid),
    .load_rdata(load_rdata), .flush(flush), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall_req(stall_req),
    .retire_count(retire_count)
  );

  wb_stage #(.XLEN(32), .CNT_W(4)) u_dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .load_valid(load_valid),
    .load_rdata(load_rdata), .flush(flush), .wb_valid(s_wb_valid), .wb_we(s_wb_we),
    .wb_rd(s_wb_rd), .wb_data(s_wb_data), .stall_req(s_stall_req),
    .retire_count(s_retire_count)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] rdata);
    logic [31:0] b, h;
    int unsigned sh_b, sh_h;
    sh_b = 8 * int'(lo);
    sh_h = 16 * (int'(lo) / 2);
    b = (rdata >> sh_b) & 32'h0000_00FF;
    h = (rdata >> sh_h) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h1_0000 : h;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] ref_data(input logic [1:0] sel, input logic [31:0] alu,
                                           input logic [31:0] pc4, input logic [31:0] imm,
                                           input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] rdata);
    if (sel == 2'd0) return alu;
    if (sel == 2'd2) return pc4;
    if (sel == 2'd3) return imm;
    return ref_load(f3, lo, rdata);
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int when, input logic [4:0] rd, input logic we,
                          input logic [31:0] data);
    exp_q.push_back({32'(when), rd, we, data});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (mon_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !exp_wait});
      chk("stall_req", {31'd0, stall_req}, {31'd0, exp_wait});
      if (wb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wb_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          exp_count++;
          chk("retire_cycle", 32'(cyc), e[69:38]);
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e[37:33]});
          chk("wb_we", {31'd0, wb_we}, {31'd0, e[32]});
          chk("wb_data", wb_data, e[31:0]);
          chk("retire_count", retire_count, 32'(exp_count));
          chk("retire_count_wrap4", {28'd0, s_retire_count}, {28'd0, 4'(exp_count)});
        end
      end else begin
        chk("wb_valid_known", {31'd0, wb_valid}, 32'd0);
        chk("wb_we_idle", {31'd0, wb_we}, 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_fields();
    in_rd         = 5'($urandom);
    in_reg_write  = 1'($urandom);
    in_wb_sel     = 2'($urandom);
    in_alu_result = $urandom;
    in_pc_plus4   = $urandom;
    in_imm        = $urandom;
    in_funct3     = 3'($urandom);
    in_addr_lo    = 2'($urandom);
  endtask

  task automatic issue(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rdata,
                       input int delay, input bit flush_accept, input bit flush_wait);
    logic [31:0] exp;
    logic        exp_we;
    exp    = ref_data(sel, alu, pc4, imm, f3, lo, rdata);
    exp_we = rw && (rd != 5'd0);
    exp_wait = 1'b0;
    in_valid = 1'b1;
    in_rd = rd; in_reg_write = rw; in_wb_sel = sel;
    in_alu_result = alu; in_pc_plus4 = pc4; in_imm = imm;
    in_funct3 = f3; in_addr_lo = lo;
    flush = flush_accept;
    // Load data only counts as same-cycle when this is a load with no delay.
    load_valid = (sel == 2'b01 && delay == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    load_rdata = (sel == 2'b01) ? rdata : $urandom;
    if (sel == 2'b01 && delay > 0) load_valid = 1'b0;
    if (!flush_accept && (sel != 2'b01 || delay == 0)) push_exp(cyc + 1, rd, exp_we, exp);
    step();
    in_valid = 1'b0; flush = 1'b0; load_valid = 1'b0;
    if (!flush_accept && sel == 2'b01 && delay > 0) begin
      for (int k = 1; k < delay; k++) begin
        exp_wait = 1'b1;
        junk_fields();
        in_valid = 1'($urandom_range(0, 1));
        load_rdata = $urandom;
        step();
      end
      exp_wait = 1'b1;
      junk_fields();
      in_valid = 1'($urandom_range(0, 1));
      load_valid = 1'b1;
      load_rdata = rdata;
      flush = flush_wait;
      if (!flush_wait) push_exp(cyc + 1, rd, exp_we, exp);
      step();
      load_valid = 1'b0; flush = 1'b0; in_valid = 1'b0;
    end
    exp_wait = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wb_we"}, {31'd0, wb_we}, 32'd0);
    chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_retire_count"}, retire_count, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_stall_req"}, {31'd0, stall_req}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; load_valid = 1'b0;
    junk_fields();
    load_rdata = 32'd0;
    step(); step();
    reset = 1'b0;
    check_reset_outputs("reset");
    mon_en = 1'b1;

    // Directed cases
    issue(5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0, 0, 1'b0, 1'b0);
    issue(5'd7, 1'b1, 2'b01, 32'h0, 32'h0, 32'h0, 3'b000, 2'd3, 32'h80FF7F01, 3, 1'b0, 1'b0);
    issue(5'd8, 1'b1, 2'b01, 32'h0, 32'h0, 32'h0, 3'b100, 2'd3, 32'h80FF7F01, 3, 1'b0, 1'b0);
    issue(5'd9, 1'b1, 2'b01, 32'h0, 32'h0, 32'h0, 3'b001, 2'd2, 32'h8001FFFF, 0, 1'b0, 1'b0);
    issue(5'd10, 1'b1, 2'b01, 32'h0, 32'h0, 32'h0, 3'b101, 2'd0, 32'h8001FFFF, 0, 1'b0, 1'b0);
    issue(5'd11, 1'b1, 2'b01, 32'h0, 32'h0, 32'h0, 3'b010, 2'd1, 32'hDEADBEEF, 2, 1'b0, 1'b1);
    issue(5'd0, 1'b1, 2'b10, 32'h0, 32'h104, 32'h0, 3'd0, 2'd0, 32'h0, 0, 1'b0, 1'b0);
    issue(5'd12, 1'b1, 2'b11, 32'h0, 32'h0, 32'hABCDE000, 3'd0, 2'd0, 32'h0, 0, 1'b1, 1'b0);
    issue(5'd13, 1'b1, 2'b11, 32'h0, 32'h0, 32'hABCDE000, 3'd0, 2'd0, 32'h0, 0, 1'b0, 1'b0);
    issue(5'd14, 1'b1, 2'b01, 32'h0, 32'h0, 32'h0, 3'b110, 2'd1, 32'h12345678, 1, 1'b0, 1'b0);

    // Random traffic, enough retirements to wrap the 4-bit counter many times
    for (int n = 0; n < 300; n++) begin
      logic [1:0] sel;
      sel = 2'($urandom);
      issue(5'($urandom), 1'($urandom), sel, $urandom, $urandom, $urandom,
            3'($urandom), 2'($urandom), $urandom, int'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        junk_fields();
        in_valid = 1'b0;
        load_valid = 1'($urandom);
        step();
        load_valid = 1'b0;
      end
    end

    // Reset while a load is outstanding; the late data must not retire.
    junk_fields();
    in_valid = 1'b1; in_wb_sel = 2'b01; load_valid = 1'b0;
    step();
    in_valid = 1'b0; exp_wait = 1'b1;
    step();
    reset = 1'b1; load_valid = 1'b1;
    step();
    reset = 1'b0; load_valid = 1'b0; exp_wait = 1'b0; exp_count = 0;
    check_reset_outputs("midreset");
    load_valid = 1'b1; load_rdata = $urandom;
    step();
    load_valid = 1'b0;
    step();

    issue(5'd3, 1'b1, 2'b00, 32'hCAFE0001, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0, 0, 1'b0, 1'b0);
    issue(5'd4, 1'b1, 2'b01, 32'h0, 32'h0, 32'h0, 3'b000, 2'd1, 32'h0000_7F00, 1, 1'b0, 1'b0);
    step(); step();
    mon_en = 1'b0;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_retire_count", retire_count, 32'(exp_count));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
